// File: rtl/cut_pkg.sv
// Shared types and constants for the cut sequencer.
// Holds the state encoding and the ms prescaler width helper.
package cut_pkg;

   localparam int CNT_W_DEF      = 7;
   localparam int CLK_PER_MS_DEF = 50000;
   localparam int MS_W           = $clog2(CLK_PER_MS_DEF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CUT,
      S_GAP,
      S_DONE,
      S_ERR
   } state_e;

   function automatic int ms_w(input int clk_per_ms);
      return (clk_per_ms > 1) ? $clog2(clk_per_ms) : 1;
   endfunction

endpackage

// File: rtl/cut_sequencer_if.sv
// Controller/driver signal bundle of the cut sequencer.
// master drives requests and the stroke flag; slave is the sequencer.
interface cut_sequencer_if
   import cut_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             start_i;
   logic             abort_i;
   logic [CNT_W-1:0] cut_num_i;
   logic             cut_o;
   logic             cut_end_i;
   logic             feed_o;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] cut_cnt_o;
   logic             err_o;

   modport master (
      output start_i, abort_i, cut_num_i, cut_end_i,
      input  cut_o, feed_o, busy_o, done_o, cut_cnt_o, err_o
   );

   modport slave (
      input  start_i, abort_i, cut_num_i, cut_end_i,
      output cut_o, feed_o, busy_o, done_o, cut_cnt_o, err_o
   );

endinterface

// File: rtl/ms_ticker.sv
// Millisecond prescaler: one-cycle tick every CLK_PER_MS clocks.
// clr restarts the count so a new phase starts on a full ms.
module ms_ticker
   import cut_pkg::*;
#(
   parameter int CLK_PER_MS = CLK_PER_MS_DEF,
   parameter int W          = ms_w(CLK_PER_MS)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_o
);

   localparam logic [W-1:0] TC = W'(CLK_PER_MS - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == TC);

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cut_sequencer.sv
// Batch cut sequencer: cut stroke, count, timed feed gap, repeat.
// Optional per-stroke watchdog enabled by CUT_SEQ_TIMEOUT_EN.
module cut_sequencer
   import cut_pkg::*;
#(
   parameter int CLK_PER_MS = CLK_PER_MS_DEF,
   parameter int GAP_MS     = 200,
   parameter int TIMEOUT_MS = 5000,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   cut_sequencer_if.slave bus
);

   localparam int GAP_W = $clog2(GAP_MS + 1);

   if (GAP_MS < 1 || TIMEOUT_MS < 1) begin : g_cfg_chk
      $error("cut_sequencer: GAP_MS and TIMEOUT_MS must be >= 1");
   end

   state_e           state_q, state_d;
   logic [2:0]       sync_q, sync_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             cut_q, cut_d;
   logic             feed_q, feed_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             stroke_end;
   logic             ms_tick;
   logic             wd_expired;

   // two sync stages then an edge register; a wide pulse yields one edge
   assign sync_d     = {sync_q[1:0], bus.cut_end_i};
   assign stroke_end = sync_q[1] & ~sync_q[2];

   ms_ticker #(
      .CLK_PER_MS(CLK_PER_MS)
   ) u_ms_ticker (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_d != state_q),
      .tick_o(ms_tick)
   );

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      if (bus.abort_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i && bus.cut_num_i != '0) begin
                  target_d = bus.cut_num_i;
                  cnt_d    = '0;
                  state_d  = S_CUT;
               end
            end
            S_CUT: begin
               if (stroke_end) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  gap_d   = GAP_W'(GAP_MS);
                  state_d = (cnt_d == target_q) ? S_DONE : S_GAP;
               end else if (wd_expired) begin
                  state_d = S_ERR;
               end
            end
            S_GAP: begin
               if (ms_tick) begin
                  gap_d = gap_q - GAP_W'(1);
                  if (gap_q == GAP_W'(1)) state_d = S_CUT;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
      cut_d  = (state_d == S_CUT);
      feed_d = (state_d == S_GAP);
      busy_d = (state_d inside {S_CUT, S_GAP, S_DONE});
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sync_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         cut_q    <= 1'b0;
         feed_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         cut_q    <= cut_d;
         feed_q   <= feed_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef CUT_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_MS + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;

   // held at zero outside CUT, so every stroke starts a fresh window
   assign wd_expired = ms_tick && (wd_q == WD_W'(TIMEOUT_MS - 1));

   always_comb begin
      wd_d  = wd_q;
      if (state_q != S_CUT) wd_d = '0;
      else if (ms_tick)     wd_d = wd_q + WD_W'(1);
      err_d = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign bus.err_o = err_q;
`else
   assign wd_expired = 1'b0;
   assign bus.err_o  = 1'b0;
`endif

   assign bus.cut_o     = cut_q;
   assign bus.feed_o    = feed_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.cut_cnt_o = cnt_q;

endmodule

// File: tb/tb_cut_sequencer.sv
// Self-checking bench for cut_sequencer with a behavioural driver model.
// Define CUT_SEQ_TIMEOUT_EN to also exercise the stroke watchdog.
module tb_cut_sequencer;

   localparam int CPM     = 4;
   localparam int GAP     = 2;
   localparam int TMO     = 5;
   localparam int CW      = 7;
   localparam int GAP_CYC = GAP * CPM;
   localparam int SYNC    = 3;
`ifdef CUT_SEQ_TIMEOUT_EN
   localparam int BAS_DLY = 12;
   localparam int BAS_W   = 4;
   localparam int MIN_DLY = 5;
   localparam int MAX_DLY = 14;
   localparam int MAX_W   = 4;
   localparam int HOLD    = 15;
`else
   localparam int BAS_DLY = 100;
   localparam int BAS_W   = 20;
   localparam int MIN_DLY = 20;
   localparam int MAX_DLY = 60;
   localparam int MAX_W   = 20;
   localparam int HOLD    = 200;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   cut_sequencer_if #(.CNT_W(CW)) bus ();

   cut_sequencer #(
      .CLK_PER_MS(CPM),
      .GAP_MS    (GAP),
      .TIMEOUT_MS(TMO),
      .CNT_W     (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   cut_rises, done_cnt, busy_len, cut_len, feed_len;
   int   cut_runs[$];
   int   feed_runs[$];
   logic cut_prev, feed_prev;
   bit   drv_en;
   int   drv_age, drv_delay, drv_width;

   // one clock: sample at negedge, record runs, run the driver model
   task automatic step();
      @(negedge clk);
      if (bus.cut_o && !cut_prev) cut_rises++;
      if (bus.cut_o) cut_len++;
      else if (cut_len > 0) begin cut_runs.push_back(cut_len); cut_len = 0; end
      if (bus.feed_o) feed_len++;
      else if (feed_len > 0) begin feed_runs.push_back(feed_len); feed_len = 0; end
      if (bus.done_o) done_cnt++;
      if (bus.busy_o) busy_len++;
      if (drv_en) begin
         if (bus.cut_o && !cut_prev) drv_age = 0;
         else if (drv_age >= 0) drv_age++;
         bus.cut_end_i = (drv_age >= drv_delay) && (drv_age < drv_delay + drv_width);
         if (drv_age >= drv_delay + drv_width) drv_age = -1;
      end
      cut_prev  = bus.cut_o;
      feed_prev = bus.feed_o;
   endtask

   task automatic clear_stats();
      cut_rises = 0; done_cnt = 0; busy_len = 0; cut_len = 0; feed_len = 0;
      cut_runs.delete(); feed_runs.delete();
      drv_age = -1;
   endtask

   task automatic start_batch(input int n);
      bus.cut_num_i = CW'(n);
      bus.start_i   = 1'b1;
      step();
      bus.start_i   = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_cnt > 0 && !bus.busy_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({bus.cut_o, bus.feed_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got=%b want=00000",
            {bus.cut_o, bus.feed_o, bus.busy_o, bus.done_o, bus.err_o});
      end
      checks++;
      if (bus.cut_cnt_o !== '0) begin
         errors++; $display("FAIL reset_cnt got=%0d want=0", bus.cut_cnt_o);
      end
      rst = 1'b0;
      repeat (2) step();
      checks++;
      if (bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset busy=%b want=0", bus.busy_o);
      end
   endtask

   task automatic test_basic();
      bit ok;
      clear_stats();
      drv_en = 1'b1; drv_delay = BAS_DLY; drv_width = BAS_W;
      start_batch(3);
      checks++;
      if (bus.cut_o !== 1'b1) begin
         errors++; $display("FAIL basic_first_cut cut_o=%b want=1", bus.cut_o);
      end
      wait_done(3000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout done=%0d want=1", done_cnt); end
      checks++;
      if (cut_rises != 3 || done_cnt != 1) begin
         errors++; $display("FAIL basic_pulses cuts=%0d done=%0d want=3,1", cut_rises, done_cnt);
      end
      checks++;
      if (feed_runs.size() != 2) begin
         errors++; $display("FAIL basic_gaps got=%0d want=2", feed_runs.size());
      end
      foreach (feed_runs[i]) begin
         checks++;
         if (feed_runs[i] != GAP_CYC) begin
            errors++; $display("FAIL basic_gap_len got=%0d want=%0d", feed_runs[i], GAP_CYC);
         end
      end
      checks++;
      if (bus.cut_cnt_o !== CW'(3) || bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
         errors++; $display("FAIL basic_end cnt=%0d busy=%b err=%b want=3,0,0",
            bus.cut_cnt_o, bus.busy_o, bus.err_o);
      end
   endtask

   task automatic test_zero_start();
      start_batch(0);
      repeat (5) step();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.cut_o !== 1'b0 || bus.cut_cnt_o !== CW'(3)) begin
         errors++; $display("FAIL zero_start busy=%b cut=%b cnt=%0d want=0,0,3",
            bus.busy_o, bus.cut_o, bus.cut_cnt_o);
      end
   endtask

   task automatic test_random();
      bit ok;
      int n, exp_busy;
      for (int k = 0; k < 4; k++) begin
         clear_stats();
         n         = $urandom_range(1, 5);
         drv_delay = $urandom_range(MIN_DLY, MAX_DLY);
         drv_width = $urandom_range(2, MAX_W);
         // each stroke: driver delay + sync latency; gaps between; one DONE
         exp_busy  = n * (drv_delay + SYNC) + (n - 1) * GAP_CYC + 1;
         start_batch(n);
         wait_done(3000, ok);
         checks++;
         if (!ok || bus.cut_cnt_o !== CW'(n) || cut_rises != n || done_cnt != 1) begin
            errors++; $display("FAIL rand_batch ok=%0d cnt=%0d cuts=%0d done=%0d want n=%0d",
               ok, bus.cut_cnt_o, cut_rises, done_cnt, n);
         end
         checks++;
         if (busy_len != exp_busy) begin
            errors++; $display("FAIL rand_busy_len got=%0d want=%0d", busy_len, exp_busy);
         end
         checks++;
         if (feed_runs.size() != n - 1) begin
            errors++; $display("FAIL rand_gaps got=%0d want=%0d", feed_runs.size(), n - 1);
         end
         foreach (cut_runs[i]) begin
            checks++;
            if (cut_runs[i] != drv_delay + SYNC) begin
               errors++; $display("FAIL rand_cut_len got=%0d want=%0d",
                  cut_runs[i], drv_delay + SYNC);
            end
         end
      end
   endtask

   task automatic test_busy_start();
      bit ok;
      clear_stats();
      drv_en = 1'b1; drv_delay = MIN_DLY; drv_width = 3;
      start_batch(2);
      for (int i = 0; i < 200 && !bus.feed_o; i++) step();
      checks++;
      if (bus.feed_o !== 1'b1) begin errors++; $display("FAIL busy_start_gap feed=%b want=1", bus.feed_o); end
      start_batch(9);
      wait_done(1000, ok);
      checks++;
      if (!ok || bus.cut_cnt_o !== CW'(2) || cut_rises != 2) begin
         errors++; $display("FAIL busy_start ok=%0d cnt=%0d cuts=%0d want 2,2",
            ok, bus.cut_cnt_o, cut_rises);
      end
   endtask

   task automatic test_wide_pulse();
      bit ok;
      clear_stats();
      drv_en = 1'b0;
      start_batch(2);
      repeat (5) step();
      bus.cut_end_i = 1'b1;
      repeat (HOLD) step();
      checks++;
      if (bus.cut_cnt_o !== CW'(1) || bus.cut_o !== 1'b1 || feed_runs.size() != 1) begin
         errors++; $display("FAIL wide_once cnt=%0d cut=%b gaps=%0d want 1,1,1",
            bus.cut_cnt_o, bus.cut_o, feed_runs.size());
      end
      bus.cut_end_i = 1'b0;
      repeat (5) step();
      bus.cut_end_i = 1'b1;
      wait_done(50, ok);
      bus.cut_end_i = 1'b0;
      checks++;
      if (!ok || bus.cut_cnt_o !== CW'(2) || done_cnt != 1) begin
         errors++; $display("FAIL wide_fresh ok=%0d cnt=%0d done=%0d want 1,2,1",
            ok, bus.cut_cnt_o, done_cnt);
      end
   endtask

   task automatic test_abort_collision();
      clear_stats();
      drv_en = 1'b0;
      start_batch(4);
      repeat (10) step();
      bus.cut_end_i = 1'b1;
      repeat (4) step();
      bus.cut_end_i = 1'b0;
      for (int i = 0; i < 50 && !bus.cut_o; i++) step();
      checks++;
      if (bus.cut_o !== 1'b1 || bus.cut_cnt_o !== CW'(1)) begin
         errors++; $display("FAIL abort_pre cut=%b cnt=%0d want 1,1", bus.cut_o, bus.cut_cnt_o);
      end
      // edge becomes visible two clocks after the raise; abort lands on it
      bus.cut_end_i = 1'b1;
      repeat (2) step();
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      checks++;
      if ({bus.cut_o, bus.feed_o, bus.busy_o, bus.done_o} !== 4'b0 || bus.cut_cnt_o !== CW'(1)) begin
         errors++; $display("FAIL abort_now flags=%b cnt=%0d want 0000,1",
            {bus.cut_o, bus.feed_o, bus.busy_o, bus.done_o}, bus.cut_cnt_o);
      end
      bus.cut_end_i = 1'b0;
      repeat (10) step();
      checks++;
      if (done_cnt != 0 || bus.busy_o !== 1'b0 || bus.cut_cnt_o !== CW'(1)) begin
         errors++; $display("FAIL abort_after done=%0d busy=%b cnt=%0d want 0,0,1",
            done_cnt, bus.busy_o, bus.cut_cnt_o);
      end
   endtask

   task automatic test_reset_mid_gap();
      bit ok;
      clear_stats();
      drv_en = 1'b1; drv_delay = MIN_DLY; drv_width = 3;
      start_batch(3);
      for (int i = 0; i < 200 && !bus.feed_o; i++) step();
      rst = 1'b1; drv_en = 1'b0; bus.cut_end_i = 1'b0;
      step();
      rst = 1'b0;
      checks++;
      if ({bus.cut_o, bus.feed_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0
          || bus.cut_cnt_o !== '0) begin
         errors++; $display("FAIL reset_gap flags=%b cnt=%0d want 00000,0",
            {bus.cut_o, bus.feed_o, bus.busy_o, bus.done_o, bus.err_o}, bus.cut_cnt_o);
      end
      repeat (5) step();
      checks++;
      if (done_cnt != 0) begin errors++; $display("FAIL reset_gap_done got=%0d want=0", done_cnt); end
      clear_stats();
      drv_en = 1'b1;
      start_batch(2);
      wait_done(1000, ok);
      checks++;
      if (!ok || bus.cut_cnt_o !== CW'(2) || cut_rises != 2 || done_cnt != 1) begin
         errors++; $display("FAIL reset_rerun ok=%0d cnt=%0d cuts=%0d done=%0d want 1,2,2,1",
            ok, bus.cut_cnt_o, cut_rises, done_cnt);
      end
   endtask

`ifdef CUT_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      clear_stats();
      drv_en = 1'b0; bus.cut_end_i = 1'b0;
      start_batch(1);
      repeat (TMO * CPM - 1) step();
      checks++;
      if (bus.err_o !== 1'b0 || bus.cut_o !== 1'b1) begin
         errors++; $display("FAIL tmo_early err=%b cut=%b want 0,1", bus.err_o, bus.cut_o);
      end
      step();
      checks++;
      if (bus.err_o !== 1'b1 || bus.cut_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL tmo_err err=%b cut=%b busy=%b want 1,0,0",
            bus.err_o, bus.cut_o, bus.busy_o);
      end
      start_batch(1);
      checks++;
      if (bus.err_o !== 1'b1 || bus.cut_o !== 1'b0) begin
         errors++; $display("FAIL tmo_sticky err=%b cut=%b want 1,0", bus.err_o, bus.cut_o);
      end
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      checks++;
      if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++; $display("FAIL tmo_abort err=%b busy=%b want 0,0", bus.err_o, bus.busy_o);
      end
   endtask
`endif

   initial begin
      bus.start_i = 1'b0; bus.abort_i = 1'b0;
      bus.cut_num_i = '0; bus.cut_end_i = 1'b0;
      drv_en = 1'b0; cut_prev = 1'b0; feed_prev = 1'b0;
      clear_stats();
      test_reset();
      test_basic();
      test_zero_start();
      test_random();
      test_busy_start();
      test_wide_pulse();
      test_abort_collision();
      test_reset_mid_gap();
`ifdef CUT_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
